// File: rtl/biu_bus_arbiter.sv
// biu_bus_arbiter
// Shares the 16-bit bus interface unit between the fetch control unit (FCU) and
// the execution unit (EU). Level requests are arbitrated round-robin, one owner
// at a time. The owner's transfer select is latched at grant and presented to the
// BIU while chip select is high. The arbiter waits for ready_bus, pulses done to
// the owner for one cycle, and then forces a turnaround cycle before the next
// grant. If the BIU never answers, the transfer is released after TIMEOUT_CYC
// busy cycles and a sticky timeout flag is raised.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_fcu, sel_fcu_in   fetch unit request (level) and transfer select
//   req_eu, sel_eu_in     execution unit request (level) and transfer select
//   ready_bus             BIU transfer-complete strobe
//   cs_biu, sel_biu       BIU chip select and transfer select
//   gnt_fcu, gnt_eu       bus ownership (BUSY and RELEASE)
//   done_fcu, done_eu     one-cycle completion pulses
//   timeout_err           sticky BIU timeout flag, cleared only by reset

module biu_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_fcu,
    input  logic [1:0] sel_fcu_in,
    input  logic       req_eu,
    input  logic [1:0] sel_eu_in,
    input  logic       ready_bus,
    output logic       cs_biu,
    output logic [1:0] sel_biu,
    output logic       gnt_fcu,
    output logic       gnt_eu,
    output logic       done_fcu,
    output logic       done_eu,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StRelease
    } state_t;

    state_t           state;
    logic             owner;       // 0 = FCU, 1 = EU
    logic             last_owner;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] tcnt;

    logic grant_eu;
    logic timeout_hit;

    // EU wins when it is the only requester, or on a tie when FCU owned last.
    assign grant_eu    = req_eu && (!req_fcu || !last_owner);
    assign timeout_hit = (tcnt == CNT_W'(TIMEOUT_CYC - 1));

    // Select is forced to zero whenever the BIU is not selected.
    assign sel_biu = cs_biu ? sel_q : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            owner       <= 1'b0;
            last_owner  <= 1'b1;
            sel_q       <= 2'b00;
            tcnt        <= '0;
            cs_biu      <= 1'b0;
            gnt_fcu     <= 1'b0;
            gnt_eu      <= 1'b0;
            done_fcu    <= 1'b0;
            done_eu     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_fcu || req_eu) begin
                        state  <= StBusy;
                        tcnt   <= '0;
                        cs_biu <= 1'b1;
                        owner  <= grant_eu;
                        sel_q  <= grant_eu ? sel_eu_in : sel_fcu_in;
                        gnt_eu  <= grant_eu;
                        gnt_fcu <= !grant_eu;
                    end
                end
                StBusy: begin
                    tcnt <= tcnt + CNT_W'(1);
                    // ready_bus takes precedence over a coincident timeout.
                    if (ready_bus || timeout_hit) begin
                        state    <= StRelease;
                        cs_biu   <= 1'b0;
                        done_eu  <= owner;
                        done_fcu <= !owner;
                        if (!ready_bus) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                StRelease: begin
                    // Always return to idle: this is the bus turnaround cycle.
                    state      <= StIdle;
                    last_owner <= owner;
                    gnt_fcu    <= 1'b0;
                    gnt_eu     <= 1'b0;
                    done_fcu   <= 1'b0;
                    done_eu    <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/biu_bus_arbiter.md
Name: biu_bus_arbiter

Overview:
- Sequences the shared 16-bit bus interface unit between its two masters: the fetch control unit (instruction fetch) and the execution unit (operand read/write).
- Accepts level requests from both masters and grants exactly one at a time, using round-robin priority.
- Drives the BIU chip-select and transfer select, waits for the BIU ready_bus completion, returns a one-cycle done pulse to the owner, and enforces a bus turnaround cycle.
- Flags a sticky error if the BIU fails to complete within a bounded time.

Parameters:
- TIMEOUT_CYC, 16: maximum cycles in BUSY without ready_bus before forced release; legal range 2..31.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_fcu  input  1  fetch unit bus request; level, held until done_fcu.
- sel_fcu_in  input  2  transfer select requested by the fetch unit.
- req_eu  input  1  execution unit bus request; level, held until done_eu.
- sel_eu_in  input  2  transfer select requested by the execution unit.
- ready_bus  input  1  BIU transfer-complete strobe.
- cs_biu  output  1  BIU chip select; high only in BUSY.
- sel_biu  output  2  transfer select presented to the BIU; latched at grant.
- gnt_fcu  output  1  fetch unit owns the bus (BUSY or RELEASE).
- gnt_eu  output  1  execution unit owns the bus (BUSY or RELEASE).
- done_fcu  output  1  one-cycle completion pulse to the fetch unit.
- done_eu  output  1  one-cycle completion pulse to the execution unit.
- timeout_err  output  1  sticky BIU timeout flag.

Behaviour:
- States: IDLE, BUSY, RELEASE. Registers: state, owner (0 = FCU, 1 = EU), last_owner, sel_q, tcnt[CNT_W-1:0], timeout_err.
- Reset values: state = IDLE, last_owner = 1 (so FCU wins the first tie), tcnt = 0, sel_q = 2'b00. All outputs = 0.
- Reset asserted mid-transfer aborts immediately. No done pulse is issued. The BIU sees cs_biu = 0 on the next cycle.
- IDLE, one request only: that requester is granted.
- IDLE, both requests: the requester not equal to last_owner is granted.
- On a grant edge: state goes to BUSY, owner is set, sel_q takes the owner's sel_*_in, tcnt is cleared.
- Grant latency: a request sampled high in IDLE at edge N gives cs_biu = 1 and gnt_* = 1 after edge N.
- BUSY outputs: cs_biu = 1, sel_biu = sel_q, gnt_<owner> = 1. tcnt increments every cycle.
- BUSY completion: ready_bus = 1 at edge N moves to RELEASE after edge N.
- BUSY timeout: ready_bus = 0 with tcnt == TIMEOUT_CYC-1 at edge N sets timeout_err = 1 and moves to RELEASE.
- Timeout and ready_bus in the same cycle: ready_bus wins; timeout_err is not set.
- RELEASE: cs_biu = 0, gnt_<owner> stays 1, done_<owner> = 1 for exactly this cycle. last_owner takes owner. Next state is always IDLE, giving a mandatory turnaround cycle.
- Minimum spacing: done pulse at cycle D means the next grant is at cycle D+2 at the earliest.
- ready_bus in IDLE or RELEASE: ignored.
- Requester drops req during BUSY: the transfer still completes and done still pulses.
- sel_*_in changing after grant: no effect.
- timeout_err: cleared only by reset; it does not block further arbitration.
- Invariants: gnt_fcu and gnt_eu are never both 1. done_* is never high outside RELEASE. sel_biu = 2'b00 whenever cs_biu = 0.

Test Plan:
- Reset check: hold reset 2 cycles -> all outputs 0, state IDLE. Then req_fcu = 1, sel_fcu_in = 2'b01 -> gnt_fcu = 1, cs_biu = 1, sel_biu = 01 one cycle later.
- Single FCU transfer: ready_bus pulsed on the 3rd BUSY cycle -> cs_biu drops the next cycle, done_fcu high exactly 1 cycle, gnt_fcu low the cycle after.
- Contention: req_fcu = req_eu = 1 held continuously, ready_bus after 2 BUSY cycles each time -> grants alternate FCU, EU, FCU, EU. Exactly one idle cycle between each done pulse and the next cs_biu.
- Timeout: grant EU, never assert ready_bus, TIMEOUT_CYC = 16 -> cs_biu high exactly 16 cycles, timeout_err = 1, done_eu pulses. timeout_err stays 1 across later normal transfers until reset.
- Boundary: ready_bus coincident with tcnt == 15 -> normal completion, timeout_err stays 0.
- Reset mid-BUSY: reset asserted during an EU transfer -> next cycle cs_biu = 0, gnt_eu = 0, no done_eu. After reset with both requesting, FCU is granted first.
